sr_flag_arbiter: RTL

SR_FLAG_ARBITER -- requirements
Module: sr_flag_arbiter

---
 rtl/sr_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 34 +++
 rtl/sr_flag_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/sr_arb_pkg.sv
// Shared definitions for the SR flag arbiter: FSM state encoding and default sizes.
// The optional lock feature in sr_flag_arbiter is enabled with SR_ARB_LOCK_EN.
package sr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_N_FLAG = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping
// from N_REQ-1 back to 0.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    winner,
    output logic             valid
);

    int          sum;
    logic [PW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        sum    = 0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            idx = PW'(sum);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a shared SR flag bank.
// Define SR_ARB_LOCK_EN to add the lock input that extends a grant while lock[winner] is high.
module sr_flag_arbiter
    import sr_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int N_FLAG = DEF_N_FLAG
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*N_FLAG-1:0] set_m,
    input  logic [N_REQ*N_FLAG-1:0] clr_m,
`ifdef SR_ARB_LOCK_EN
    input  logic [N_REQ-1:0]        lock,
`endif
    output logic [N_REQ-1:0]        gnt,
    output logic [N_FLAG-1:0]       flags,
    output logic                    busy,
    output logic                    err
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t        state, state_nxt;
    logic [PW-1:0]     ptr, ptr_nxt;
    logic [PW-1:0]     win, win_nxt;
    logic [PW-1:0]     ptr_inc;
    logic [N_REQ-1:0]  gnt_nxt;
    logic [N_FLAG-1:0] flags_nxt;
    logic              err_nxt;
    logic [PW-1:0]     pick_w;
    logic              pick_v;
    logic              lock_hold;
    logic [N_FLAG-1:0] set_a [N_REQ];
    logic [N_FLAG-1:0] clr_a [N_REQ];
    logic [N_FLAG-1:0] s_w, r_w;

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign set_a[i] = set_m[i*N_FLAG +: N_FLAG];
        assign clr_a[i] = clr_m[i*N_FLAG +: N_FLAG];
    end

    assign s_w     = set_a[win];
    assign r_w     = clr_a[win];
    assign ptr_inc = (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
    assign busy    = (state != IDLE);

`ifdef SR_ARB_LOCK_EN
    assign lock_hold = lock[win];
`else
    assign lock_hold = 1'b0;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_w),
        .valid  (pick_v)
    );

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        win_nxt   = win;
        gnt_nxt   = '0;
        flags_nxt = flags;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_v) begin
                    state_nxt       = GRANT;
                    win_nxt         = pick_w;
                    gnt_nxt[pick_w] = 1'b1;
                end
            end
            GRANT: begin
                // Conflicting S=R bits keep their value; only clean set/clear bits move.
                flags_nxt = (flags & ~(r_w & ~s_w)) | (s_w & ~r_w);
                err_nxt   = |(s_w & r_w);
                if (lock_hold) begin
                    gnt_nxt = gnt;
                end else begin
                    state_nxt = GAP;
                    ptr_nxt   = ptr_inc;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
            win   <= '0;
            gnt   <= '0;
            flags <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            win   <= win_nxt;
            gnt   <= gnt_nxt;
            flags <= flags_nxt;
            err   <= err_nxt;
        end
    end

endmodule
